// File: rtl/hsi_stream_gen_mc.sv
// Multi-channel HSI test-stream generator: serialises N_CH pattern words per frame onto
// HSCK/HSDATA with a programmable half-period, a fixed idle gap, and run control.
module hsi_stream_gen_mc #(
  parameter int unsigned WORD_W   = 16,
  parameter int unsigned N_CH     = 3,
  parameter int unsigned GAP_BITS = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   hold,
  input  logic                   free_run,
  input  logic [15:0]            num_frames,
  input  logic [7:0]             clk_div,
  input  logic                   hsck_pol,
  input  logic [N_CH-1:0]        ch_enable,
  input  logic [N_CH*WORD_W-1:0] pattern,
  output logic                   hsck,
  output logic                   hsdata,
  output logic                   frame_sync,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            frame_count
);

  localparam int unsigned NBits = N_CH * WORD_W;

  typedef enum logic [2:0] {
    StIdle, StLoad, StShift, StGap, StCheck, StHold, StDone
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        nf_q, nf_d;
  logic [7:0]         half_q, half_d;
  logic               free_q, free_d;
  logic [N_CH-1:0]    en_q, en_d;
  logic               first_q, first_d;
  logic [NBits-1:0]   sreg_q, sreg_d;
  logic [8:0]         cnt_q, cnt_d;
  logic [8:0]         bit_q, bit_d;
  logic               hsck_int_q, hsck_int_d;
  logic               hsdata_q, hsdata_d;
  logic               sync_q, sync_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [15:0]        fcnt_q, fcnt_d;

  logic [N_CH-1:0]    en_eff;
  logic [NBits-1:0]   frame_vec;
  logic [8:0]         period_last;

  // Last cycle index of one 2H-cycle bit period.
  assign period_last = {half_q, 1'b0} - 9'd1;

  // Frame word with channel 0 at the MSB end; the first LOAD of a run uses the live enables.
  always_comb begin
    frame_vec = '0;
    en_eff    = first_q ? ch_enable : en_q;
    for (int ch = 0; ch < N_CH; ch++) begin
      frame_vec[NBits-1-ch*WORD_W -: WORD_W] =
          en_eff[ch] ? pattern[ch*WORD_W +: WORD_W] : '0;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
  always_comb begin
    state_d    = state_q;
    nf_d       = nf_q;
    half_d     = half_q;
    free_d     = free_q;
    en_d       = en_q;
    first_d    = first_q;
    sreg_d     = sreg_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    hsck_int_d = 1'b0;
    hsdata_d   = 1'b0;
    sync_d     = 1'b0;
    fcnt_d     = fcnt_q;

    case (state_q)
      StIdle: begin
        if (start && !stop) begin
          fcnt_d = '0;
          if (!free_run && (num_frames == 16'd0)) begin
            state_d = StDone;
          end else begin
            state_d = StLoad;
            first_d = 1'b1;
          end
        end
      end

      StLoad: begin
        if (first_q) begin
          nf_d   = num_frames;
          half_d = (clk_div == 8'd0) ? 8'd1 : clk_div;
          free_d = free_run;
          en_d   = ch_enable;
        end
        first_d    = 1'b0;
        // First bit goes straight to the output register; the rest wait in sreg.
        hsdata_d   = frame_vec[NBits-1];
        sreg_d     = frame_vec << 1;
        hsck_int_d = 1'b1;
        sync_d     = 1'b1;
        cnt_d      = '0;
        bit_d      = '0;
        state_d    = StShift;
      end

      StShift: begin
        if (cnt_q == period_last) begin
          cnt_d = '0;
          if (bit_q == 9'(NBits - 1)) begin
            bit_d   = '0;
            state_d = StGap;
          end else begin
            bit_d      = bit_q + 9'd1;
            hsck_int_d = 1'b1;
            hsdata_d   = sreg_q[NBits-1];
            sreg_d     = sreg_q << 1;
          end
        end else begin
          cnt_d      = cnt_q + 9'd1;
          hsck_int_d = ((cnt_q + 9'd1) < {1'b0, half_q});
          hsdata_d   = hsdata_q;
          sync_d     = sync_q;
        end
      end

      StGap: begin
        if (cnt_q == period_last) begin
          cnt_d = '0;
          if (bit_q == 9'(GAP_BITS - 1)) begin
            bit_d   = '0;
            fcnt_d  = fcnt_q + 16'd1;
            state_d = StCheck;
          end else begin
            bit_d = bit_q + 9'd1;
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end

      StCheck: begin
        if (hold) begin
          state_d = StHold;
        end else if (stop) begin
          state_d = StDone;
        end else if (!free_q && (fcnt_q == nf_q)) begin
          state_d = StDone;
        end else begin
          state_d = StLoad;
        end
      end

      StHold: begin
        if (!hold) begin
          state_d = StCheck;
        end
      end

      StDone: begin
        if (!start) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    busy_d = !((state_d == StIdle) || (state_d == StDone));
    done_d = (state_d == StDone);
  end

  // State and output registers; reset lands everything at the idle values immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      nf_q       <= '0;
      half_q     <= 8'd1;
      free_q     <= 1'b0;
      en_q       <= '0;
      first_q    <= 1'b0;
      sreg_q     <= '0;
      cnt_q      <= '0;
      bit_q      <= '0;
      hsck_int_q <= 1'b0;
      hsdata_q   <= 1'b0;
      sync_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      nf_q       <= nf_d;
      half_q     <= half_d;
      free_q     <= free_d;
      en_q       <= en_d;
      first_q    <= first_d;
      sreg_q     <= sreg_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      hsck_int_q <= hsck_int_d;
      hsdata_q   <= hsdata_d;
      sync_q     <= sync_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fcnt_q     <= fcnt_d;
    end
  end

  assign hsck        = hsck_int_q ^ hsck_pol;
  assign hsdata      = hsdata_q;
  assign frame_sync  = sync_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frame_count = fcnt_q;

endmodule

// File: tb/tb_hsi_stream_gen_mc.sv
// Bench for hsi_stream_gen_mc: table of run configurations plus hand sequences for
// hold/stop, stop-in-idle and reset mid-frame; serial bits checked via a scoreboard queue.
module tb_hsi_stream_gen_mc;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        hold = 1'b0;
  logic        free_run = 1'b0;
  logic [15:0] num_frames = '0;
  logic [7:0]  clk_div = 8'd1;
  logic        hsck_pol = 1'b0;
  logic [2:0]  ch_enable = 3'b111;
  logic [47:0] pattern = '0;
  logic        hsck, hsdata, frame_sync, busy, done;
  logic [15:0] frame_count;

  hsi_stream_gen_mc #(
    .WORD_W  (16),
    .N_CH    (3),
    .GAP_BITS(4)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .stop       (stop),
    .hold       (hold),
    .free_run   (free_run),
    .num_frames (num_frames),
    .clk_div    (clk_div),
    .hsck_pol   (hsck_pol),
    .ch_enable  (ch_enable),
    .pattern    (pattern),
    .hsck       (hsck),
    .hsdata     (hsdata),
    .frame_sync (frame_sync),
    .busy       (busy),
    .done       (done),
    .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;

  // Posedge counter used to time events seen at the negedge.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard and monitor state.
  logic        exp_q[$];
  logic        exp_b;
  logic        cur_int;
  logic        prev_int = 1'b0;
  logic        prev_sync = 1'b0;
  int unsigned rises = 0;
  int unsigned syncs = 0;
  int unsigned sync_w = 0;
  int unsigned exp_h = 1;
  int unsigned exp_period = 0;
  int unsigned first_sync_cyc = 0;
  int unsigned last_sync_cyc = 0;

  // Monitor: on each hsck_int rise pop one expected bit; track frame_sync width and spacing.
  always @(negedge clock) begin
    cur_int = hsck ^ hsck_pol;
    if (cur_int && !prev_int) begin
      rises++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL extra_bit: hsck rise %0d with no expected bit (cycle %0d)", rises, cyc);
      end else begin
        exp_b = exp_q.pop_front();
        check("hsdata", {31'd0, hsdata}, {31'd0, exp_b});
      end
    end
    if (frame_sync) begin
      if (!prev_sync) begin
        syncs++;
        if (syncs == 1) first_sync_cyc = cyc;
        else if (exp_period != 0) check("frame_period", cyc - last_sync_cyc, exp_period);
        last_sync_cyc = cyc;
      end
      sync_w++;
    end else if (prev_sync) begin
      check("sync_width", sync_w, 2 * exp_h);
      sync_w = 0;
    end
    prev_int  = cur_int;
    prev_sync = frame_sync;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Expected serial stream of one frame: channel 0 first, MSB first, disabled channels zero.
  task automatic push_frame(input logic [47:0] pat, input logic [2:0] en);
    for (int ch = 0; ch < 3; ch++) begin
      for (int b = 15; b >= 0; b--) begin
        exp_q.push_back(en[ch] ? pat[ch*16+b] : 1'b0);
      end
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: done timeout after %0d cycles, got 0, expected 1", name, budget);
    end
  endtask

  task automatic new_run(input int unsigned h, input int unsigned period);
    rises      = 0;
    syncs      = 0;
    exp_h      = h;
    exp_period = period;
  endtask

  typedef struct {
    logic [7:0]  clk_div;
    logic [2:0]  en;
    logic        pol;
    logic [47:0] pat;
    logic [15:0] nf;
    int unsigned period;
    int unsigned h;
  } vec_t;

  vec_t        vecs[5];
  vec_t        v;
  int unsigned t0;
  logic [47:0] p0;
  logic [47:0] p_rst;

  initial begin
    p0    = {16'h0003, 16'h0002, 16'h9381};
    p_rst = {16'hC3A5, 16'hF0F0, 16'h5A5A};
    //          clk_div  en      pol   pattern                              nf     period h
    vecs[0] = '{8'd1, 3'b111, 1'b0, p0,                                  16'd1, 106, 1};
    vecs[1] = '{8'd3, 3'b111, 1'b0, p0,                                  16'd3, 314, 3};
    vecs[2] = '{8'd0, 3'b111, 1'b0, {16'h8001, 16'h7FFE, 16'h0F0F},     16'd2, 106, 1};
    vecs[3] = '{8'd2, 3'b010, 1'b1, {16'hA5A5, 16'h1234, 16'hFFFF},     16'd1, 210, 2};
    vecs[4] = '{8'd1, 3'b111, 1'b0, p0,                                  16'd0, 0,   1};

    // Reset state.
    tick(3);
    check("rst_hsck", {31'd0, hsck}, 32'd0);
    check("rst_hsdata", {31'd0, hsdata}, 32'd0);
    check("rst_sync", {31'd0, frame_sync}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_fcount", {16'd0, frame_count}, 32'd0);
    reset_n = 1'b1;
    tick(2);

    // Table-driven finite runs.
    for (int i = 0; i < 5; i++) begin
      v          = vecs[i];
      clk_div    = v.clk_div;
      ch_enable  = v.en;
      hsck_pol   = v.pol;
      pattern    = v.pat;
      num_frames = v.nf;
      free_run   = 1'b0;
      tick(1);
      check("idle_hsck_level", {31'd0, hsck}, {31'd0, v.pol});
      new_run(v.h, v.period);
      for (int f = 0; f < int'(v.nf); f++) push_frame(v.pat, v.en);
      start = 1'b1;
      t0    = cyc;
      wait_done("run_done", int'(v.nf) * 400 + 50);
      check("run_fcount", {16'd0, frame_count}, {16'd0, v.nf});
      check("run_rises", rises, 48 * int'(v.nf));
      check("run_syncs", syncs, {16'd0, v.nf});
      check("run_queue_left", exp_q.size(), 0);
      check("run_busy_at_done", {31'd0, busy}, 32'd0);
      if (v.nf != 16'd0) check("start_latency", first_sync_cyc - t0, 2);
      tick(5);
      check("done_held_by_start", {31'd0, done}, 32'd1);
      start = 1'b0;
      tick(2);
      check("done_clears", {31'd0, done}, 32'd0);
      exp_q.delete();
    end
    hsck_pol = 1'b0;

    // stop held in IDLE blocks start.
    new_run(1, 0);
    clk_div    = 8'd1;
    num_frames = 16'd1;
    stop       = 1'b1;
    start      = 1'b1;
    tick(5);
    check("stop_idle_busy", {31'd0, busy}, 32'd0);
    check("stop_idle_rises", rises, 0);
    start = 1'b0;
    stop  = 1'b0;
    tick(2);

    // Free run with hold after frame 2 and stop after frame 4.
    new_run(1, 0);
    ch_enable  = 3'b111;
    pattern    = p0;
    free_run   = 1'b1;
    num_frames = 16'd1;
    repeat (4) push_frame(p0, 3'b111);
    start = 1'b1;
    for (int k = 0; k < 400 && syncs < 2; k++) @(negedge clock);
    check("fr_reach_frame2", syncs, 2);
    tick(10);
    hold = 1'b1;
    for (int k = 0; k < 400 && frame_count != 16'd2; k++) @(negedge clock);
    tick(20);
    check("hold_fcount", {16'd0, frame_count}, 32'd2);
    check("hold_busy", {31'd0, busy}, 32'd1);
    check("hold_hsck", {31'd0, hsck}, 32'd0);
    check("hold_hsdata", {31'd0, hsdata}, 32'd0);
    check("hold_rises", rises, 96);
    hold = 1'b0;
    t0   = cyc;
    for (int k = 0; k < 20 && syncs < 3; k++) @(negedge clock);
    // One CHECK cycle and one LOAD cycle sit between hold release and the first bit.
    check("hold_release_latency", last_sync_cyc - t0, 3);
    for (int k = 0; k < 400 && syncs < 4; k++) @(negedge clock);
    tick(10);
    stop = 1'b1;
    wait_done("stop_done", 400);
    check("stop_fcount", {16'd0, frame_count}, 32'd4);
    check("stop_rises", rises, 192);
    check("stop_queue_left", exp_q.size(), 0);
    stop     = 1'b0;
    start    = 1'b0;
    free_run = 1'b0;
    tick(2);
    exp_q.delete();

    // Reset mid-frame, then a clean run.
    new_run(3, 0);
    clk_div    = 8'd3;
    pattern    = p_rst;
    num_frames = 16'd1;
    push_frame(p_rst, 3'b111);
    start = 1'b1;
    for (int k = 0; k < 400 && rises < 20; k++) @(negedge clock);
    check("mid_hsck_high", {31'd0, hsck}, 32'd1);
    check("mid_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    start   = 1'b0;
    #1;
    check("arst_hsck", {31'd0, hsck}, 32'd0);
    check("arst_hsdata", {31'd0, hsdata}, 32'd0);
    check("arst_sync", {31'd0, frame_sync}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    exp_q.delete();
    tick(2);
    reset_n = 1'b1;
    tick(2);
    new_run(3, 0);
    push_frame(p_rst, 3'b111);
    start = 1'b1;
    t0    = cyc;
    wait_done("post_rst_done", 450);
    check("post_rst_fcount", {16'd0, frame_count}, 32'd1);
    check("post_rst_rises", rises, 48);
    check("post_rst_queue_left", exp_q.size(), 0);
    check("post_rst_latency", first_sync_cyc - t0, 2);
    start = 1'b0;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
